// File: rtl/multicycle_controller.sv
// multicycle_controller: sequencing FSM for the multi-cycle RV32I core (fetch/decode/exec/mem/wb).
// Latency: lw 5, sw/R/I/jal 4, branch 3 cycles, plus one cycle per memory wait cycle.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold with mem_req/AdrSrc stable until mem_ready.
// Optional feature: define MC_JAL_EN to add the JAL state and the J-type immediate select.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       sign_flag,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       instr_retire,
  output logic       trap
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
`ifdef MC_JAL_EN
    S_JAL      = 4'd10,
`endif
    S_TRAP     = 4'd15
  } state_t;

  state_t state_q, state_d;

  // State register; reset restarts at FETCH, which also clears the trap condition.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Immediate format select, decoded straight from the opcode as in the single-cycle decoder.
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_STORE:  ImmSrc = 2'b01;
      OP_BRANCH: ImmSrc = 2'b10;
`ifdef MC_JAL_EN
      OP_JAL:    ImmSrc = 2'b11;
`endif
      default:   ImmSrc = 2'b00;
    endcase
  end

  // Next-state and per-state datapath controls; reset masks every strobe.
  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    AdrSrc       = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    MemWrite     = 1'b0;
    RegWrite     = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    instr_retire = 1'b0;
    trap         = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC+4 is on the result bus the whole time; it is only committed on ready.
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // OldPC + imm lands in ALUOut as the branch/jump target.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
`ifdef MC_JAL_EN
          OP_JAL:            state_d = S_JAL;
`endif
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc    = 2'b01;
        RegWrite     = 1'b1;
        instr_retire = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        // MemWrite is held through wait cycles so the memory sees one stable request.
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          instr_retire = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite     = 1'b1;
        instr_retire = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        // Compare rs1 - rs2 while ALUOut (the target) drives the result bus.
        ALUSrcA      = 2'b10;
        ALUOp        = 2'b01;
        instr_retire = 1'b1;
        case (funct3)
          3'b000:  PCWrite = Zero;
          3'b001:  PCWrite = ~Zero;
          3'b100:  PCWrite = sign_flag;
          default: PCWrite = 1'b0;
        endcase
        state_d = S_FETCH;
      end
`ifdef MC_JAL_EN
      S_JAL: begin
        // Target from DECODE goes to PC; ALU forms OldPC+4 for the link write in ALUWB.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
`endif
      S_TRAP: begin
        trap    = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_FETCH;
    endcase
    if (reset) begin
      mem_req      = 1'b0;
      IRWrite      = 1'b0;
      PCWrite      = 1'b0;
      MemWrite     = 1'b0;
      RegWrite     = 1'b0;
      instr_retire = 1'b0;
      trap         = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized instruction streams against a phase-level reference model.
// Latency: checks every cycle of every instruction, including memory wait cycles.
// Backpressure: mem_ready is randomly withheld in FETCH/MEMREAD/MEMWRITE and toggled elsewhere.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       Zero, sign_flag, mem_ready;
  logic       mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic       instr_retire, trap;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .Zero(Zero),
    .sign_flag(sign_flag), .mem_ready(mem_ready), .mem_req(mem_req),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
    .instr_retire(instr_retire), .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, adr, irw, pcw, memw, regw, ret, trp;
    logic [1:0] rs, sa, sb, aop;
  } ctl_t;

  typedef enum {P_FETCH, P_DEC, P_MADR, P_MRD, P_MWB, P_MWR, P_EXR, P_EXI,
                P_AWB, P_BR, P_JAL, P_TRAP} ph_e;
  typedef enum {K_LW, K_SW, K_R, K_I, K_BR, K_JAL, K_ILL} kind_e;

  ctl_t got;
  assign got = {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, instr_retire, trap,
                ResultSrc, ALUSrcA, ALUSrcB, ALUOp};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] strb(input ctl_t c);
    return {c.mem_req, c.irw, c.pcw, c.memw, c.regw, c.ret, c.trp};
  endfunction

  // Per-phase control values as listed in the state table; unlisted outputs are 0.
  function automatic ctl_t exp_of(input ph_e p, input logic rdy, input logic tk);
    ctl_t c = '0;
    case (p)
      P_FETCH: begin c.mem_req = 1; c.sb = 2'b10; c.rs = 2'b10; c.irw = rdy; c.pcw = rdy; end
      P_DEC:   begin c.sa = 2'b01; c.sb = 2'b01; end
      P_MADR:  begin c.sa = 2'b10; c.sb = 2'b01; end
      P_MRD:   begin c.mem_req = 1; c.adr = 1; end
      P_MWB:   begin c.rs = 2'b01; c.regw = 1; c.ret = 1; end
      P_MWR:   begin c.mem_req = 1; c.adr = 1; c.memw = 1; c.ret = rdy; end
      P_EXR:   begin c.sa = 2'b10; c.sb = 2'b00; c.aop = 2'b10; end
      P_EXI:   begin c.sa = 2'b10; c.sb = 2'b01; c.aop = 2'b10; end
      P_AWB:   begin c.regw = 1; c.ret = 1; end
      P_BR:    begin c.sa = 2'b10; c.aop = 2'b01; c.ret = 1; c.pcw = tk; end
      P_JAL:   begin c.sa = 2'b01; c.sb = 2'b10; c.pcw = 1; end
      default: begin c.trp = 1; end
    endcase
    return c;
  endfunction

  function automatic kind_e classify(input logic [6:0] o);
    case (o)
      7'b0000011: return K_LW;
      7'b0100011: return K_SW;
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b1100011: return K_BR;
`ifdef MC_JAL_EN
      7'b1101111: return K_JAL;
`endif
      default:    return K_ILL;
    endcase
  endfunction

  function automatic logic [1:0] imm_exp(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
`ifdef MC_JAL_EN
    if (o == 7'b1101111) return 2'b11;
`endif
    return 2'b00;
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic z, input logic s);
    return (f3 == 3'd0 && z) || (f3 == 3'd1 && !z) || (f3 == 3'd4 && s);
  endfunction

  // One reset cycle: strobes must be quiet, and the following cycle must be FETCH.
  task automatic do_reset(input logic rdy);
    reset = 1'b1; mem_ready = rdy; Zero = 1'($urandom); sign_flag = 1'($urandom);
    @(negedge clk);
    chk("rst_strobes", 32'(strb(got)), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_fetch", {16'd0, got}, {16'd0, exp_of(P_FETCH, 1'b0, 1'b0)});
    @(posedge clk); #1;
  endtask

  // Runs one instruction from FETCH; abort_at >= 0 resets the core before that cycle.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic z,
                           input logic s, input int fw, input int mw, input int abort_at);
    ph_e   qp[$];
    logic  qr[$];
    kind_e kd = classify(o);
    int    cpi = 0;
    int    ret_idx = -1;
    int    nret = 0;
    logic  tk = taken(f3, z, s);
    for (int k = 0; k < fw; k++) begin qp.push_back(P_FETCH); qr.push_back(1'b0); end
    qp.push_back(P_FETCH); qr.push_back(1'b1);
    qp.push_back(P_DEC);   qr.push_back(1'b0);
    case (kd)
      K_LW: begin
        qp.push_back(P_MADR); qr.push_back(1'b0);
        for (int k = 0; k < mw; k++) begin qp.push_back(P_MRD); qr.push_back(1'b0); end
        qp.push_back(P_MRD); qr.push_back(1'b1);
        qp.push_back(P_MWB); qr.push_back(1'b0);
        cpi = 5 + fw + mw;
      end
      K_SW: begin
        qp.push_back(P_MADR); qr.push_back(1'b0);
        for (int k = 0; k < mw; k++) begin qp.push_back(P_MWR); qr.push_back(1'b0); end
        qp.push_back(P_MWR); qr.push_back(1'b1);
        cpi = 4 + fw + mw;
      end
      K_R:   begin qp.push_back(P_EXR); qp.push_back(P_AWB); qr.push_back(0); qr.push_back(0); cpi = 4 + fw; end
      K_I:   begin qp.push_back(P_EXI); qp.push_back(P_AWB); qr.push_back(0); qr.push_back(0); cpi = 4 + fw; end
      K_BR:  begin qp.push_back(P_BR); qr.push_back(1'b0); cpi = 3 + fw; end
      K_JAL: begin qp.push_back(P_JAL); qp.push_back(P_AWB); qr.push_back(0); qr.push_back(0); cpi = 4 + fw; end
      default: for (int k = 0; k < 20; k++) begin qp.push_back(P_TRAP); qr.push_back(1'b0); end
    endcase
    op = o; funct3 = f3;
    for (int i = 0; i < qp.size(); i++) begin
      ph_e p = qp[i];
      if (i == abort_at) begin
        do_reset(1'b1);
        return;
      end
      if (p == P_FETCH || p == P_MRD || p == P_MWR) mem_ready = qr[i];
      else mem_ready = 1'($urandom);
      if (p == P_BR) begin Zero = z; sign_flag = s; end
      else begin Zero = 1'($urandom); sign_flag = 1'($urandom); end
      @(negedge clk);
      chk($sformatf("ctl_%s_op%b_c%0d", p.name(), o, i), {16'd0, got},
          {16'd0, exp_of(p, qr[i], tk)});
      if (p == P_DEC) chk("immsrc", 32'(ImmSrc), 32'(imm_exp(o)));
      if (instr_retire) begin nret++; ret_idx = i; end
      @(posedge clk); #1;
    end
    if (kd == K_ILL) begin
      do_reset(1'($urandom));
    end else begin
      chk($sformatf("cpi_op%b", o), 32'(ret_idx + 1), 32'(cpi));
      chk("retire_count", 32'(nret), 32'd1);
    end
  endtask

  initial begin
    logic [6:0] legal[6];
    logic [6:0] illegal[6];
    legal   = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    illegal = '{7'b0000000, 7'b1111111, 7'b0110111, 7'b0010111, 7'b1100111, 7'b1110011};
    reset = 1'b1; op = 7'b0; funct3 = 3'b0; Zero = 1'b0; sign_flag = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_strobes_init", 32'(strb(got)), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed cases from the bring-up list.
    run_instr(7'b0010011, 3'b000, 0, 0, 0, 0, -1);  // addi
    run_instr(7'b0000011, 3'b010, 0, 0, 2, 3, -1);  // lw, 10 cycles
    run_instr(7'b0100011, 3'b010, 0, 0, 0, 2, -1);  // sw, 3 MemWrite cycles
    run_instr(7'b1100011, 3'b000, 1, 0, 0, 0, -1);  // beq taken
    run_instr(7'b1100011, 3'b000, 0, 1, 0, 0, -1);  // beq not taken
    run_instr(7'b1100011, 3'b100, 0, 1, 0, 0, -1);  // blt taken
    run_instr(7'b1100011, 3'b010, 1, 1, 0, 0, -1);  // unsupported funct3: not taken
    run_instr(7'b0110011, 3'b000, 0, 0, 1, 0, -1);  // R-type
    run_instr(7'b0000000, 3'b000, 0, 0, 0, 0, -1);  // illegal -> trap, reset
    run_instr(7'b1101111, 3'b000, 0, 0, 0, 0, -1);  // jal (traps when not built in)
    run_instr(7'b0100011, 3'b010, 0, 0, 0, 2, 4);   // reset during store wait
    run_instr(7'b0000011, 3'b010, 0, 0, 1, 2, 4);   // reset during load wait

    // Randomized instruction stream.
    for (int n = 0; n < 150; n++) begin
      logic [6:0] o;
      if ($urandom_range(0, 15) == 0) o = illegal[$urandom_range(0, 5)];
      else o = legal[$urandom_range(0, 5)];
      run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 4)) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
